// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: state encodings, default stall bound, stall-length helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the hazard unit and the controller both import this header.
`ifndef PIPELINE_CTRL_PKG_SV
`define PIPELINE_CTRL_PKG_SV

package pipeline_ctrl_pkg;

  // Longest stall a single hazard request may ask for.
  localparam int MAX_STALL_DEF = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } ctrl_state_e;

  // Per-cycle pipeline register controls.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_bubble;
    logic ifid_flush;
  } ctrl_out_t;

  // Effective stall length: a request of 0 still costs one cycle, and long
  // requests are clamped to the configured bound.
  function automatic logic [1:0] eff_cycles(input logic [1:0] hc, input int max_stall);
    int n;
    n = (hc == 2'd0) ? 1 : int'(hc);
    if (n > max_stall) n = max_stall;
    if (n < 1) n = 1;
    return n[1:0];
  endfunction

endpackage

`endif

// File: rtl/pipeline_ctrl_if.sv
// Hazard/branch request inputs and pipeline-register control outputs of the pipeline controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; freeze is the only hold and travels as a plain level.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             haz_req;
  logic [1:0]       haz_cycles;
  logic             branch_taken;
  logic             freeze;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Hazard unit / core side that raises requests and consumes the enables.
  modport master (
    output haz_req, haz_cycles, branch_taken, freeze,
    input  pc_we, ifid_we, idex_bubble, ifid_flush, busy, stall_count, flush_count
  );

  // The controller itself.
  modport slave (
    input  haz_req, haz_cycles, branch_taken, freeze,
    output pc_we, ifid_we, idex_bubble, ifid_flush, busy, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for pipeline event statistics.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: turns hazard, taken-branch and freeze into PC/IF/ID/ID/EX controls.
// Latency: enables are combinational from inputs and state (Mealy); busy and counters are registered.
// Backpressure: freeze holds all state and counters; branch_taken overrides hazards and active stalls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = MAX_STALL_DEF
) (
  input logic           clk,
  input logic           rst_n,
  pipeline_ctrl_if.slave ctl
);
  ctrl_state_e      state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       n_eff;
  ctrl_out_t        ctrl_o;
  logic             stall_inc;
  logic             flush_inc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign n_eff = eff_cycles(ctl.haz_cycles, MAX_STALL);

  // State and remaining-stall-cycle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and per-cycle controls; priority is reset, freeze, branch, then hazard/stall.
  always_comb begin
    state_d            = state_q;
    rem_d              = rem_q;
    ctrl_o.pc_we       = 1'b1;
    ctrl_o.ifid_we     = 1'b1;
    ctrl_o.idex_bubble = 1'b0;
    ctrl_o.ifid_flush  = 1'b0;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;

    if (!rst_n) begin
      // Hold the pipeline with a bubble in ID/EX while reset is applied.
      ctrl_o.pc_we       = 1'b0;
      ctrl_o.ifid_we     = 1'b0;
      ctrl_o.idex_bubble = 1'b1;
    end else if (ctl.freeze) begin
      ctrl_o.pc_we       = 1'b0;
      ctrl_o.ifid_we     = 1'b0;
      ctrl_o.idex_bubble = 1'b0;
    end else if (ctl.branch_taken) begin
      // Redirect: PC takes the target, wrong-path IF/ID and ID/EX are squashed.
      ctrl_o.pc_we       = 1'b1;
      ctrl_o.ifid_we     = 1'b0;
      ctrl_o.idex_bubble = 1'b1;
      ctrl_o.ifid_flush  = 1'b1;
      flush_inc          = 1'b1;
      state_d            = ST_RUN;
      rem_d              = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ctl.haz_req) begin
            ctrl_o.pc_we       = 1'b0;
            ctrl_o.ifid_we     = 1'b0;
            ctrl_o.idex_bubble = 1'b1;
            stall_inc          = 1'b1;
            rem_d              = n_eff - 2'd1;
            state_d            = (n_eff > 2'd1) ? ST_STALL : ST_RUN;
          end
        end
        ST_STALL: begin
          ctrl_o.pc_we       = 1'b0;
          ctrl_o.ifid_we     = 1'b0;
          ctrl_o.idex_bubble = 1'b1;
          stall_inc          = 1'b1;
          if (rem_q <= 2'd1) begin
            // Last stall cycle (rem==0 cannot occur here, but recover to RUN if it does).
            rem_d   = '0;
            state_d = ST_RUN;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign ctl.pc_we       = ctrl_o.pc_we;
  assign ctl.ifid_we     = ctrl_o.ifid_we;
  assign ctl.idex_bubble = ctrl_o.idex_bubble;
  assign ctl.ifid_flush  = ctrl_o.ifid_flush;
  assign ctl.busy        = (state_q == ST_STALL);
  assign ctl.stall_count = stall_cnt;
  assign ctl.flush_count = flush_cnt;
endmodule
